// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, load and mul/div results onto the single register-file write port.
// Optional macro WB_STARVE_EN lets a starved ld/md hold preempt the ALU after STARVE_LIMIT lost cycles.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_idx,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_idx,
    input  logic [31:0] ld_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_idx,
    input  logic [31:0] md_data,
    output logic        wr_en,
    output logic [4:0]  wr_idx,
    output logic [31:0] wr_data,
    output logic [31:0] pending_mask
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic        ld_hold_v_q, ld_hold_v_d;
    logic [4:0]  ld_hold_idx_q, ld_hold_idx_d;
    logic [31:0] ld_hold_data_q, ld_hold_data_d;
    logic        md_hold_v_q, md_hold_v_d;
    logic [4:0]  md_hold_idx_q, md_hold_idx_d;
    logic [31:0] md_hold_data_q, md_hold_data_d;
    logic        rr_q, rr_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic alu_req, alu_grant, ld_grant, md_grant, preempt;
    logic ld_fire, md_fire;

`ifdef WB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign preempt   = (starve_q >= LIMIT) & (ld_hold_v_q | md_hold_v_q);
    assign alu_stall = preempt & alu_valid;

    always_comb begin
        starve_d = starve_q;
        if (ld_grant || md_grant || !(ld_hold_v_q || md_hold_v_q)) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'd15) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign preempt   = 1'b0;
    assign alu_stall = 1'b0;
`endif

    // A destination of x0 never requests; the ALU wins unless a starved hold preempts it.
    always_comb begin
        alu_req   = alu_valid & (alu_idx != 5'd0);
        alu_grant = alu_req & ~preempt;
        ld_grant  = 1'b0;
        md_grant  = 1'b0;
        if (!alu_grant) begin
            if (ld_hold_v_q && (!md_hold_v_q || !rr_q)) begin
                ld_grant = 1'b1;
            end else if (md_hold_v_q) begin
                md_grant = 1'b1;
            end
        end
    end

    assign ld_ready = ~ld_hold_v_q | ld_grant;
    assign md_ready = ~md_hold_v_q | md_grant;
    assign ld_fire  = ld_valid & ld_ready;
    assign md_fire  = md_valid & md_ready;

    always_comb begin
        ld_hold_v_d    = ld_hold_v_q & ~ld_grant;
        ld_hold_idx_d  = ld_hold_idx_q;
        ld_hold_data_d = ld_hold_data_q;
        if (ld_fire && ld_idx != 5'd0) begin
            ld_hold_v_d    = 1'b1;
            ld_hold_idx_d  = ld_idx;
            ld_hold_data_d = ld_data;
        end
        md_hold_v_d    = md_hold_v_q & ~md_grant;
        md_hold_idx_d  = md_hold_idx_q;
        md_hold_data_d = md_hold_data_q;
        if (md_fire && md_idx != 5'd0) begin
            md_hold_v_d    = 1'b1;
            md_hold_idx_d  = md_idx;
            md_hold_data_d = md_data;
        end
    end

    always_comb begin
        wr_en_d   = alu_grant | ld_grant | md_grant;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (alu_grant) begin
            wr_idx_d  = alu_idx;
            wr_data_d = alu_data;
        end else if (ld_grant) begin
            wr_idx_d  = ld_hold_idx_q;
            wr_data_d = ld_hold_data_q;
        end else if (md_grant) begin
            wr_idx_d  = md_hold_idx_q;
            wr_data_d = md_hold_data_q;
        end
        rr_d = rr_q ^ (ld_grant | md_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_hold_v_q    <= 1'b0;
            ld_hold_idx_q  <= 5'd0;
            ld_hold_data_q <= 32'd0;
            md_hold_v_q    <= 1'b0;
            md_hold_idx_q  <= 5'd0;
            md_hold_data_q <= 32'd0;
            rr_q           <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_idx_q       <= 5'd0;
            wr_data_q      <= 32'd0;
        end else begin
            ld_hold_v_q    <= ld_hold_v_d;
            ld_hold_idx_q  <= ld_hold_idx_d;
            ld_hold_data_q <= ld_hold_data_d;
            md_hold_v_q    <= md_hold_v_d;
            md_hold_idx_q  <= md_hold_idx_d;
            md_hold_data_q <= md_hold_data_d;
            rr_q           <= rr_d;
            wr_en_q        <= wr_en_d;
            wr_idx_q       <= wr_idx_d;
            wr_data_q      <= wr_data_d;
        end
    end

    always_comb begin
        pending_mask = 32'd0;
        if (ld_hold_v_q) pending_mask[ld_hold_idx_q] = 1'b1;
        if (md_hold_v_q) pending_mask[md_hold_idx_q] = 1'b1;
        if (wr_en_q)     pending_mask[wr_idx_q]      = 1'b1;
    end

    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written reset and
// starvation sequences, then randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_idx = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        alu_stall;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [4:0]  ld_idx = 5'd0;
   logic [31:0] ld_data = 32'd0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_idx = 5'd0;
   logic [31:0] md_data = 32'd0;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic [31:0] pending_mask;

   int checks = 0;
   int failures = 0;

   wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_stall(alu_stall),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_data(ld_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_idx(md_idx), .md_data(md_data),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pending_mask(pending_mask)
   );

   // Free-running clock; rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   typedef struct {
      logic        av; logic [4:0] ai; logic [31:0] ad;
      logic        lv; logic [4:0] li; logic [31:0] ldd;
      logic        mv; logic [4:0] mi; logic [31:0] mdd;
      logic        e_en; logic [4:0] e_idx; logic [31:0] e_data; logic [31:0] e_mask;
      logic        e_ldr; logic e_mdr; logic e_stall;
   } vec_t;

   vec_t vecs[$];

   typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;

   // Reference model: each hold is a queue of at most one entry, output is a plain record.
   ent_t        m_ld[$];
   ent_t        m_md[$];
   bit          m_rr;
   int          m_starve;
   bit          m_en;
   logic [4:0]  m_idx;
   logic [31:0] m_data;
   int          p_grant;
   bit          p_stall, p_ldr, p_mdr;
   logic [31:0] p_mask;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                                input logic lv, input logic [4:0] li, input logic [31:0] ldd,
                                input logic mv, input logic [4:0] mi, input logic [31:0] mdd);
      alu_valid = av; alu_idx = ai; alu_data = ad;
      ld_valid  = lv; ld_idx  = li; ld_data  = ldd;
      md_valid  = mv; md_idx  = mi; md_data  = mdd;
   endtask

   function automatic void addVec(logic av, logic [4:0] ai, logic [31:0] ad,
                                  logic lv, logic [4:0] li, logic [31:0] ldd,
                                  logic mv, logic [4:0] mi, logic [31:0] mdd,
                                  logic e_en, logic [4:0] e_idx, logic [31:0] e_data,
                                  logic [31:0] e_mask, logic e_ldr, logic e_mdr, logic e_stall);
      vec_t v;
      v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ldd = ldd;
      v.mv = mv; v.mi = mi; v.mdd = mdd;
      v.e_en = e_en; v.e_idx = e_idx; v.e_data = e_data; v.e_mask = e_mask;
      v.e_ldr = e_ldr; v.e_mdr = e_mdr; v.e_stall = e_stall;
      vecs.push_back(v);
   endfunction

   function automatic void modelReset();
      m_ld.delete(); m_md.delete();
      m_rr = 0; m_starve = 0; m_en = 0; m_idx = 5'd0; m_data = 32'd0;
   endfunction

   // Predict this cycle's grant and combinational outputs from model state plus live inputs.
   function automatic void modelEval();
      bit have;
      bit preempt;
      have = (m_ld.size() > 0) || (m_md.size() > 0);
      preempt = 0;
`ifdef WB_STARVE_EN
      preempt = have && (m_starve >= STARVE_LIMIT);
`endif
      if (alu_valid && alu_idx != 0 && !preempt) p_grant = 1;
      else if (m_ld.size() > 0 && (m_md.size() == 0 || !m_rr)) p_grant = 2;
      else if (m_md.size() > 0) p_grant = 3;
      else p_grant = 0;
      p_stall = preempt && alu_valid;
      p_ldr = (m_ld.size() == 0) || (p_grant == 2);
      p_mdr = (m_md.size() == 0) || (p_grant == 3);
      p_mask = 32'd0;
      foreach (m_ld[i]) p_mask[m_ld[i].idx] = 1'b1;
      foreach (m_md[i]) p_mask[m_md[i].idx] = 1'b1;
      if (m_en) p_mask[m_idx] = 1'b1;
   endfunction

   function automatic void modelStep();
      ent_t e;
      bit have;
      have = (m_ld.size() > 0) || (m_md.size() > 0);
      m_en = (p_grant != 0);
      case (p_grant)
         1: begin m_idx = alu_idx; m_data = alu_data; end
         2: begin e = m_ld.pop_front(); m_idx = e.idx; m_data = e.data; m_rr = !m_rr; end
         3: begin e = m_md.pop_front(); m_idx = e.idx; m_data = e.data; m_rr = !m_rr; end
         default: ;
      endcase
      if (p_grant >= 2 || !have) m_starve = 0;
      else if (m_starve < 15) m_starve++;
      if (ld_valid && p_ldr && ld_idx != 0) begin e.idx = ld_idx; e.data = ld_data; m_ld.push_back(e); end
      if (md_valid && p_mdr && md_idx != 0) begin e.idx = md_idx; e.data = md_data; m_md.push_back(e); end
   endfunction

   task automatic checkModel(input string tag);
      modelEval();
      checkOutput({tag, " wr_en"}, {31'd0, wr_en}, {31'd0, m_en});
      checkOutput({tag, " wr_idx"}, {27'd0, wr_idx}, {27'd0, m_idx});
      checkOutput({tag, " wr_data"}, wr_data, m_data);
      checkOutput({tag, " pending_mask"}, pending_mask, p_mask);
      checkOutput({tag, " ld_ready"}, {31'd0, ld_ready}, {31'd0, p_ldr});
      checkOutput({tag, " md_ready"}, {31'd0, md_ready}, {31'd0, p_mdr});
      checkOutput({tag, " alu_stall"}, {31'd0, alu_stall}, {31'd0, p_stall});
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      modelReset();
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit hold_alu, hold_ld, hold_md;

      addVec(0,0,0,           0,0,0,        0,0,0,        0,0,0,            32'h0,    1,1,0);
      addVec(1,5,32'hDEADBEEF,0,0,0,        0,0,0,        0,0,0,            32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,5,32'hDEADBEEF, 32'h20,   1,1,0);
      addVec(1,0,32'h1234,    0,0,0,        0,0,0,        0,5,32'hDEADBEEF, 32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,5,32'hDEADBEEF, 32'h0,    1,1,0);
      addVec(1,3,32'h33,      1,7,32'h11,   0,0,0,        0,5,32'hDEADBEEF, 32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,3,32'h33,       32'h88,   1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,7,32'h11,       32'h80,   1,1,0);
      addVec(0,0,0,           0,0,0,        1,10,32'hAA,  0,7,32'h11,       32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,7,32'h11,       32'h400,  1,1,0);
      addVec(0,0,0,           1,8,32'h88,   1,9,32'h99,   1,10,32'hAA,      32'h400,  1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,10,32'hAA,      32'h300,  1,0,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,8,32'h88,       32'h300,  1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,9,32'h99,       32'h200,  1,1,0);
      addVec(0,0,0,           1,4,32'h44,   0,0,0,        0,9,32'h99,       32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,9,32'h99,       32'h10,   1,1,0);
      addVec(0,0,0,           1,8,32'h18,   1,9,32'h19,   1,4,32'h44,       32'h10,   1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,4,32'h44,       32'h300,  0,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,9,32'h19,       32'h300,  1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,8,32'h18,       32'h100,  1,1,0);
      addVec(1,2,32'h22,      1,12,32'hC0,  0,0,0,        0,8,32'h18,       32'h0,    1,1,0);
      addVec(1,3,32'h23,      1,13,32'hD0,  0,0,0,        1,2,32'h22,       32'h1004, 0,1,0);
      addVec(0,0,0,           1,13,32'hD0,  0,0,0,        1,3,32'h23,       32'h1008, 1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,12,32'hC0,      32'h3000, 1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        1,13,32'hD0,      32'h2000, 1,1,0);
      addVec(0,0,0,           1,0,32'h55,   0,0,0,        0,13,32'hD0,      32'h0,    1,1,0);
      addVec(0,0,0,           0,0,0,        0,0,0,        0,13,32'hD0,      32'h0,    1,1,0);

      // Directed table: expectations are the outputs seen mid-cycle with that row applied.
      doReset();
      foreach (vecs[n]) begin
         applyStimulus(vecs[n].av, vecs[n].ai, vecs[n].ad, vecs[n].lv, vecs[n].li, vecs[n].ldd,
                       vecs[n].mv, vecs[n].mi, vecs[n].mdd);
         @(negedge clk);
         checkOutput($sformatf("vec%0d wr_en", n), {31'd0, wr_en}, {31'd0, vecs[n].e_en});
         checkOutput($sformatf("vec%0d wr_idx", n), {27'd0, wr_idx}, {27'd0, vecs[n].e_idx});
         checkOutput($sformatf("vec%0d wr_data", n), wr_data, vecs[n].e_data);
         checkOutput($sformatf("vec%0d pending_mask", n), pending_mask, vecs[n].e_mask);
         checkOutput($sformatf("vec%0d ld_ready", n), {31'd0, ld_ready}, {31'd0, vecs[n].e_ldr});
         checkOutput($sformatf("vec%0d md_ready", n), {31'd0, md_ready}, {31'd0, vecs[n].e_mdr});
         checkOutput($sformatf("vec%0d alu_stall", n), {31'd0, alu_stall}, {31'd0, vecs[n].e_stall});
         nextCycle();
      end

      // Reset asserted while a load sits in its hold register.
      doReset();
      applyStimulus(1, 1, 32'h1, 1, 6, 32'h66, 0, 0, 0);
      nextCycle();
      applyStimulus(1, 2, 32'h2, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rstmid mask before", pending_mask, 32'h42);
      checkOutput("rstmid ld_ready before", {31'd0, ld_ready}, 32'd0);
      #2 rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstmid wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("rstmid mask", pending_mask, 32'd0);
      checkOutput("rstmid ld_ready", {31'd0, ld_ready}, 32'd1);
      checkOutput("rstmid md_ready", {31'd0, md_ready}, 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("rstmid no write", {31'd0, wr_en}, 32'd0);
      nextCycle();

      // Starvation: ALU valid every cycle while load to x12 waits.
      doReset();
      applyStimulus(1, 1, 32'h100, 1, 12, 32'hC12, 0, 0, 0);
      nextCycle();
`ifdef WB_STARVE_EN
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1, 1, 32'h100 + c, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput($sformatf("starve lose%0d alu_stall", c), {31'd0, alu_stall}, 32'd0);
         nextCycle();
      end
      applyStimulus(1, 1, 32'h105, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("starve preempt alu_stall", {31'd0, alu_stall}, 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("starve write wr_en", {31'd0, wr_en}, 32'd1);
      checkOutput("starve write wr_idx", {27'd0, wr_idx}, 32'd12);
      checkOutput("starve write wr_data", wr_data, 32'hC12);
      nextCycle();
`else
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1, 1, 32'h100 + c, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput($sformatf("nostarve c%0d alu_stall", c), {31'd0, alu_stall}, 32'd0);
         checkOutput($sformatf("nostarve c%0d wr_idx", c), {27'd0, wr_idx}, 32'd1);
         checkOutput($sformatf("nostarve c%0d mask12", c), {31'd0, pending_mask[12]}, 32'd1);
         nextCycle();
      end
`endif

      // Randomized traffic with producers honouring stall/ready.
      doReset();
      hold_alu = 0; hold_ld = 0; hold_md = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!hold_alu) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom;
         end
         if (!hold_ld) begin
            ld_valid = ($urandom_range(0, 9) < 4);
            ld_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_data  = $urandom;
         end
         if (!hold_md) begin
            md_valid = ($urandom_range(0, 9) < 3);
            md_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            md_data  = $urandom;
         end
         @(negedge clk);
         checkModel($sformatf("rand%0d", cyc));
         hold_alu = p_stall;
         hold_ld  = ld_valid && !p_ldr;
         hold_md  = md_valid && !p_mdr;
         modelStep();
         nextCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
